// File: rtl/gals_producer.sv
// Producer side of the GALS path: emits 16-bit words on clock_1 into a dual-clock
// buffer, throttled by a synchronized full flag. Define PRODUCER_LFSR_EN for LFSR data.
module gals_producer #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic        clock_1,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  burst_len,
  input  logic [15:0] seed,
  input  logic        buffer_full,
  output logic        data_1_en,
  output logic [15:0] data_1,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [15:0] words_sent
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_DONE} state_t;

  state_t      r_state, w_state_nx;
  logic        r_sync1, r_full_s;
  logic [15:0] r_data_next, w_data_next_nx;
  logic [7:0]  r_remaining, w_remaining_nx;
  logic [HW-1:0] r_hold_cnt, w_hold_cnt_nx;
  logic        w_en_nx, w_busy_nx, w_done_nx, w_stall_nx;
  logic [15:0] w_data_1_nx, w_words_nx;

  function automatic logic [15:0] f_load(input logic [15:0] s);
`ifdef PRODUCER_LFSR_EN
    // an all-zero LFSR state never leaves zero
    return (s == 16'h0000) ? 16'h0001 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [15:0] f_advance(input logic [15:0] d);
`ifdef PRODUCER_LFSR_EN
    return {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
`else
    return d + 16'd1;
`endif
  endfunction

  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_full_s <= 1'b0;
    end else begin
      r_sync1  <= buffer_full;
      r_full_s <= r_sync1;
    end
  end

  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_data_next <= '0;
      r_remaining <= '0;
      r_hold_cnt  <= '0;
      data_1_en   <= 1'b0;
      data_1      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stall       <= 1'b0;
      words_sent  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_data_next <= w_data_next_nx;
      r_remaining <= w_remaining_nx;
      r_hold_cnt  <= w_hold_cnt_nx;
      data_1_en   <= w_en_nx;
      data_1      <= w_data_1_nx;
      busy        <= w_busy_nx;
      done        <= w_done_nx;
      stall       <= w_stall_nx;
      words_sent  <= w_words_nx;
    end
  end

  // remaining==0 while in SEND only occurs for a continuous (burst_len=0) run
  always_comb begin
    w_state_nx     = r_state;
    w_data_next_nx = r_data_next;
    w_remaining_nx = r_remaining;
    w_hold_cnt_nx  = r_hold_cnt;
    w_en_nx        = 1'b0;
    w_data_1_nx    = data_1;
    w_done_nx      = 1'b0;
    w_stall_nx     = 1'b0;
    w_words_nx     = words_sent;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_data_next_nx = f_load(seed);
          w_remaining_nx = burst_len;
          w_words_nx     = '0;
          w_state_nx     = S_SEND;
        end
      end
      S_SEND: begin
        if (stop) begin
          w_state_nx = S_IDLE;
        end else if (r_full_s) begin
          w_stall_nx = 1'b1;
        end else begin
          w_en_nx        = 1'b1;
          w_data_1_nx    = r_data_next;
          w_words_nx     = words_sent + 16'd1;
          w_data_next_nx = f_advance(r_data_next);
          if (r_remaining != 8'd0) w_remaining_nx = r_remaining - 8'd1;
          if (r_remaining == 8'd1) begin
            w_state_nx = S_DONE;
          end else if (HOLD_CYCLES > 0) begin
            w_state_nx    = S_HOLD;
            w_hold_cnt_nx = HW'(HOLD_CYCLES - 1);
          end
        end
      end
      S_HOLD: begin
        if (stop) begin
          w_state_nx = S_IDLE;
        end else if (r_hold_cnt == '0) begin
          w_state_nx = S_SEND;
        end else begin
          w_hold_cnt_nx = r_hold_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        if (!stop) w_done_nx = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_gals_producer.sv
// Self-checking bench for gals_producer: randomized bursts and full pulses checked
// against a transaction-level model of the expected word stream and timing.
module tb_gals_producer;

  localparam int unsigned HOLD = 3;

  logic        clock_1 = 1'b0;
  logic        reset, start, stop, buffer_full;
  logic [7:0]  burst_len;
  logic [15:0] seed;
  logic        data_1_en, busy, done, stall;
  logic [15:0] data_1, words_sent;

  gals_producer #(.HOLD_CYCLES(HOLD)) dut (
    .clock_1    (clock_1),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .burst_len  (burst_len),
    .seed       (seed),
    .buffer_full(buffer_full),
    .data_1_en  (data_1_en),
    .data_1     (data_1),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .words_sent (words_sent)
  );

  always #5 clock_1 = ~clock_1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_load(input logic [15:0] s);
`ifdef PRODUCER_LFSR_EN
    return (s == 16'h0000) ? 16'h0001 : s;
`else
    return s;
`endif
  endfunction

  // i-th word of a burst started from seed s
  function automatic logic [15:0] m_word(input logic [15:0] s, input int i);
`ifdef PRODUCER_LFSR_EN
    logic [15:0] w;
    w = m_load(s);
    for (int n = 0; n < i; n++) w = {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
    return w;
`else
    return 16'(m_load(s) + 16'(i));
`endif
  endfunction

  // edge history of the raw full flag, indexed by posedge number
  int cyc = 0;
  bit bf_hist [100000];
  always @(posedge clock_1) begin
    bf_hist[cyc] <= buffer_full;
    cyc <= cyc + 1;
  end

  logic [15:0] sq_data[$];
  int          sq_edge[$];
  int          done_cnt;
  bit          stall_seen;

  always @(negedge clock_1) begin : monitor
    int e;
    if (!reset) begin
      if (data_1_en) begin
        e = cyc - 1;
        sq_data.push_back(data_1);
        sq_edge.push_back(e);
        chk("stall_on_strobe", stall, 1'b0);
        if (e >= 2) chk("write_while_full", bf_hist[e-2], 1'b0);
      end
      if (done) done_cnt++;
      if (stall) stall_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    sq_data.delete();
    sq_edge.delete();
    done_cnt   = 0;
    stall_seen = 1'b0;
  endtask

  task automatic check_words(input logic [15:0] s);
    for (int i = 0; i < sq_data.size(); i++)
      chk($sformatf("data[%0d]", i), sq_data[i], m_word(s, i));
  endtask

  task automatic run_burst(input logic [15:0] s, input int len, input int f_at,
                           input int f_len, input bit poke);
    int k, t;
    clear_mon();
    @(negedge clock_1);
    seed = s; burst_len = len[7:0]; start = 1'b1;
    @(negedge clock_1);
    start = 1'b0; k = cyc - 1; seed = ~s;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clock_1);
      t++;
      if (f_len > 0 && t == f_at) buffer_full = 1'b1;
      if (t == f_at + f_len) buffer_full = 1'b0;
      start = (poke && t == 5);
    end
    buffer_full = 1'b0;
    start = 1'b0;
    chk("burst_timeout", t < 2000, 1'b1);
    @(negedge clock_1);
    chk("strobe_count", sq_data.size(), len);
    check_words(s);
    chk("words_sent", words_sent, len);
    chk("done_pulses", done_cnt, 1);
    chk("busy_end", busy, 1'b0);
    if (f_len == 0 && sq_edge.size() > 0) chk("first_latency", sq_edge[0] - k, 1);
    for (int i = 1; i < sq_edge.size(); i++) begin
      if (f_len == 0) chk("spacing", sq_edge[i] - sq_edge[i-1], HOLD + 1);
      else            chk("spacing_min", (sq_edge[i] - sq_edge[i-1]) >= HOLD + 1, 1'b1);
    end
  endtask

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; stop = 1'b0; buffer_full = 1'b0;
    burst_len = '0; seed = '0;
    #12;
    chk("rst_en", data_1_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_words", words_sent, 16'h0);
    @(negedge clock_1);
    reset = 1'b0;

    run_burst(16'h0010, 4, 0, 0, 1'b0);
    run_burst(16'hFFFE, 3, 0, 0, 1'b0);
    run_burst(16'h0000, 5, 0, 0, 1'b0);
    run_burst(16'h0100, 8, 6, 6, 1'b0);
    chk("stall_seen", stall_seen, 1'b1);
    run_burst(16'h2222, 4, 0, 0, 1'b1);

    for (int r = 0; r < 6; r++)
      run_burst(16'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(2, 12)),
                int'($urandom_range(0, 7)), r[0]);

    // continuous burst aborted by stop after the tenth strobe
    clear_mon();
    @(negedge clock_1);
    seed = 16'h0500; burst_len = 8'd0; start = 1'b1;
    @(negedge clock_1);
    start = 1'b0;
    t = 0;
    while (sq_data.size() < 10 && t < 500) begin
      @(negedge clock_1); #1; t++;
    end
    chk("stop_timeout", t < 500, 1'b1);
    stop = 1'b1;
    @(negedge clock_1);
    stop = 1'b0;
    chk("stop_en", data_1_en, 1'b0);
    chk("stop_busy", busy, 1'b0);
    chk("stop_stall", stall, 1'b0);
    repeat (8) @(negedge clock_1);
    chk("stop_count", sq_data.size(), 10);
    chk("stop_words", words_sent, 16'd10);
    chk("stop_done", done_cnt, 0);
    check_words(16'h0500);

    // start and stop together in IDLE
    clear_mon();
    @(negedge clock_1);
    seed = 16'h0042; burst_len = 8'd2; start = 1'b1; stop = 1'b1;
    @(negedge clock_1);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 1'b0);
    repeat (4) @(negedge clock_1);
    chk("startstop_strobes", sq_data.size(), 0);

    // asynchronous reset while a strobe is on the bus
    clear_mon();
    @(negedge clock_1);
    seed = 16'h1234; burst_len = 8'd6; start = 1'b1;
    @(negedge clock_1);
    start = 1'b0;
    t = 0;
    while (sq_data.size() < 2 && t < 200) begin
      @(negedge clock_1); #1; t++;
    end
    chk("rst_mid_timeout", t < 200, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rstm_en", data_1_en, 1'b0);
    chk("rstm_data", data_1, 16'h0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_done", done, 1'b0);
    chk("rstm_stall", stall, 1'b0);
    chk("rstm_words", words_sent, 16'h0);
    @(negedge clock_1);
    reset = 1'b0;
    run_burst(16'h7FFF, 3, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
